keypad_input: RTL and testbench

//  Initiator side of the calculator input interface; the CPU is the responder.

---
 rtl/keypad_input_if.sv | 12 +
 rtl/keypad_input.sv | 240 ++++++++++++++++++++++++
 tb/tb_keypad_input.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_input_if.sv
// Command handshake between the keypad front end (master) and the CPU (slave).
`ifndef IC_N
`define IC_N 8
`endif

interface keypad_input_if;
  logic [`IC_N-1:0] in_cmd;
  logic             in_ack;

  modport master (output in_cmd, input in_ack);
  modport slave  (input in_cmd, output in_ack);
endinterface

// File: rtl/keypad_input.sv
// Keypad front end: scans a 4x5 matrix, debounces single key presses, queues
// the mapped command codes and presents them to the CPU one at a time.
`ifndef IC_N
`define IC_N 8
`endif

module keypad_input #(
  parameter int unsigned         SCAN_DIV   = 16,
  parameter int unsigned         DEB_SCANS  = 4,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter logic [`IC_N-1:0]    IDLE_CMD   = '0,
  parameter logic [20*`IC_N-1:0] KEYMAP     = {
    `IC_N'(20), `IC_N'(19), `IC_N'(18), `IC_N'(17), `IC_N'(16),
    `IC_N'(15), `IC_N'(14), `IC_N'(13), `IC_N'(12), `IC_N'(11),
    `IC_N'(10), `IC_N'(9),  `IC_N'(8),  `IC_N'(7),  `IC_N'(6),
    `IC_N'(5),  `IC_N'(4),  `IC_N'(3),  `IC_N'(2),  `IC_N'(1)}
) (
  input  logic           clk,
  input  logic           rst,
  output logic [3:0]     row_n,
  input  logic [4:0]     col_n,
  keypad_input_if.master cpu,
  output logic           key_down,
  output logic           overflow
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [15:0]      SLOT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_LAST  = 4'(DEB_SCANS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} deb_state_t;
  typedef enum logic       {OUT_IDLE, OUT_VALID} out_state_t;

  logic [4:0]       col_meta, col_sync;
  logic [15:0]      slot_cnt;
  logic [1:0]       row_idx;
  logic             slot_last, scan_done;
  logic [4:0]       row_hits;
  logic [2:0]       hit_cnt, hit_col;
  logic [4:0]       row_key;
  logic [1:0]       acc_cnt, next_cnt;
  logic [4:0]       acc_key, next_key;
  logic             res_valid, same_key, cnt_done;
  deb_state_t       deb_state;
  logic [3:0]       deb_cnt;
  logic [4:0]       key_lat;
  logic             press_evt;
  logic [`IC_N-1:0] push_code;
  logic [`IC_N-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_empty, fifo_full, pop, push_ok;
  out_state_t       out_state;
  logic [`IC_N-1:0] cmd_q;

  function automatic logic [`IC_N-1:0] keymap_code(input logic [4:0] k);
    return KEYMAP[int'(k) * `IC_N +: `IC_N];
  endfunction

  // Two-flop synchroniser for the asynchronous column pins (idle = pulled high).
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 5'h1F;
      col_sync <= 5'h1F;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign scan_done = slot_last && (row_idx == 2'd3);

  // Fold the current row's hits into the running scan tally (0, 1 or "many").
  always_comb begin
    row_hits = ~col_sync;
    hit_cnt  = '0;
    hit_col  = '0;
    for (int c = 4; c >= 0; c--) begin
      if (row_hits[c]) begin
        hit_cnt = hit_cnt + 3'd1;
        hit_col = 3'(c);
      end
    end
    row_key  = 5'(row_idx) * 5'd5 + 5'(hit_col);
    next_cnt = acc_cnt;
    next_key = acc_key;
    if (hit_cnt == 3'd1 && acc_cnt == 2'd0) begin
      next_cnt = 2'd1;
      next_key = row_key;
    end else if (hit_cnt != 3'd0) begin
      next_cnt = 2'd2;
    end
  end

  assign res_valid = scan_done && (next_cnt == 2'd1);
  assign same_key  = res_valid && (next_key == key_lat);
  assign cnt_done  = (deb_cnt == DEB_LAST);

  // Row slot timer and row rotation; the tally restarts after row 3 is judged.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      row_idx  <= '0;
      row_n    <= 4'b1110;
      acc_cnt  <= '0;
      acc_key  <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
      row_n    <= {row_n[2:0], row_n[3]};
      acc_cnt  <= (row_idx == 2'd3) ? 2'd0 : next_cnt;
      acc_key  <= (row_idx == 2'd3) ? 5'd0 : next_key;
    end else begin
      slot_cnt <= slot_cnt + 16'd1;
    end
  end

  // Debounce: a key must be the sole key for DEB_SCANS whole scans to count, and gone as long to release.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_state <= IDLE;
      deb_cnt   <= '0;
      key_lat   <= '0;
      key_down  <= 1'b0;
      press_evt <= 1'b0;
      push_code <= IDLE_CMD;
    end else begin
      press_evt <= 1'b0;
      if (scan_done) begin
        case (deb_state)
          IDLE: begin
            if (res_valid) begin
              key_lat <= next_key;
              if (DEB_SCANS == 1) begin
                press_evt <= 1'b1;
                push_code <= keymap_code(next_key);
                key_down  <= 1'b1;
                deb_state <= HELD;
              end else begin
                deb_cnt   <= 4'd1;
                deb_state <= PRESS_CHK;
              end
            end
          end
          PRESS_CHK: begin
            if (!same_key) begin
              deb_state <= IDLE;
            end else if (cnt_done) begin
              press_evt <= 1'b1;
              push_code <= keymap_code(key_lat);
              key_down  <= 1'b1;
              deb_state <= HELD;
            end else begin
              deb_cnt <= deb_cnt + 4'd1;
            end
          end
          HELD: begin
            if (!same_key) begin
              if (DEB_SCANS == 1) begin
                key_down  <= 1'b0;
                deb_state <= IDLE;
              end else begin
                deb_cnt   <= 4'd1;
                deb_state <= REL_CHK;
              end
            end
          end
          REL_CHK: begin
            if (same_key) begin
              deb_state <= HELD;
            end else if (cnt_done) begin
              key_down  <= 1'b0;
              deb_state <= IDLE;
            end else begin
              deb_cnt <= deb_cnt + 4'd1;
            end
          end
          default: deb_state <= IDLE;
        endcase
      end
    end
  end

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign pop        = (out_state == OUT_IDLE) && !fifo_empty;
  assign push_ok    = press_evt && (!fifo_full || pop);

  // Queue storage; a simultaneous pop frees the slot a full-queue push lands in.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_code;
    end
  end

  // Queue pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push_ok && pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (press_evt && !push_ok) overflow <= 1'b1;
    end
  end

  // CPU handshake: present one code, hold it until acked, then show idle for at least a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_IDLE;
      cmd_q     <= IDLE_CMD;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (!fifo_empty) begin
            cmd_q     <= fifo_mem[rd_ptr];
            out_state <= OUT_VALID;
          end
        end
        OUT_VALID: begin
          if (cpu.in_ack) begin
            cmd_q     <= IDLE_CMD;
            out_state <= OUT_IDLE;
          end
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

  assign cpu.in_cmd = cmd_q;

endmodule

// File: tb/tb_keypad_input.sv
// Self-checking bench for keypad_input: a board model closes the row/column loop,
// a monitor records presented commands, and each task checks one scenario.
`timescale 1ns/1ps
`ifndef IC_N
`define IC_N 8
`endif

module tb_keypad_input;
  localparam int SCAN_DIV   = 4;
  localparam int DEB_SCANS  = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int SCAN_LEN   = 4 * SCAN_DIV;
  localparam int LAT_MAX    = (DEB_SCANS + 1) * SCAN_LEN + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [4:0]  col_n;
  logic        key_down, overflow;
  logic [19:0] keys = '0;
  int          checks = 0;
  int          errors = 0;

  keypad_input_if cif();

  keypad_input #(
    .SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .cpu(cif), .key_down(key_down), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Board: a held key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 5'h1F;
    for (int r = 0; r < 4; r++) begin
      if (row_n[r] == 1'b0) col_n = col_n & ~keys[r*5 +: 5];
    end
  end

  // Reference keymap: key k produces code k+1.
  function automatic logic [`IC_N-1:0] exp_code(input int k);
    return `IC_N'(k + 1);
  endfunction

  int   cyc = 0;
  logic ack_at_edge = 1'b0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    ack_at_edge <= cif.in_ack;
    rst_at_edge <= rst;
  end

  // Monitor: logs each new command, key_down edges, and any illegal change of in_cmd.
  logic [`IC_N-1:0] obs_q[$];
  logic [`IC_N-1:0] prev_cmd = '0;
  logic prev_kd = 1'b0;
  int stab_err = 0, kd_rises = 0, kd_falls = 0, cmd_rise_cyc = 0, kd_rise_cyc = 0;
  always @(negedge clk) begin
    if (!rst_at_edge) begin
      if (prev_cmd != '0 && cif.in_cmd != prev_cmd && !ack_at_edge) stab_err++;
      if (prev_cmd != '0 && ack_at_edge && cif.in_cmd != '0) stab_err++;
      if (prev_cmd == '0 && cif.in_cmd != '0) begin
        obs_q.push_back(cif.in_cmd);
        cmd_rise_cyc = cyc;
      end
      if (!prev_kd && key_down) begin
        kd_rises++;
        kd_rise_cyc = cyc;
      end
      if (prev_kd && !key_down) kd_falls++;
    end
    prev_cmd = cif.in_cmd;
    prev_kd  = key_down;
  end

  // CPU model: acknowledges each presented command after ack_delay cycles.
  logic auto_ack = 1'b0;
  int   ack_delay = 0;
  initial begin
    cif.in_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && !rst && cif.in_cmd != '0) begin
        repeat (ack_delay) @(negedge clk);
        cif.in_ack = 1'b1;
        @(negedge clk);
        cif.in_ack = 1'b0;
      end
    end
  end

  task automatic clear_log();
    obs_q.delete();
    stab_err = 0;
    kd_rises = 0;
    kd_falls = 0;
  endtask

  task automatic do_reset();
    auto_ack = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    auto_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (row_n !== 4'b1110) begin errors++; $display("[TB] FAIL reset_row_n: got %b expected 1110", row_n); end
    checks++; if (cif.in_cmd !== '0) begin errors++; $display("[TB] FAIL reset_in_cmd: got %0d expected 0", cif.in_cmd); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_down: got %b expected 0", key_down); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((n / SCAN_DIV) % 4));
      checks++;
      if (row_n !== exp_row) begin
        errors++;
        $display("[TB] FAIL scan_row_n cycle %0d: got %b expected %b", n, row_n, exp_row);
      end
    end
  endtask

  task automatic test_single_press();
    int press_cyc;
    clear_log();
    auto_ack  = 1'b1;
    ack_delay = 3;
    @(negedge clk);
    keys[7]   = 1'b1;
    press_cyc = cyc;
    repeat (200) @(negedge clk);
    keys[7] = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (obs_q.size() != 1) begin errors++; $display("[TB] FAIL single_cmd_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== exp_code(7)) begin errors++; $display("[TB] FAIL single_cmd_value: got %0d expected %0d", obs_q[0], exp_code(7)); end
      checks++; if (cmd_rise_cyc - press_cyc > LAT_MAX) begin errors++; $display("[TB] FAIL single_latency_stable: got %0d expected <= %0d", cmd_rise_cyc - press_cyc, LAT_MAX); end
      checks++; if (cmd_rise_cyc - kd_rise_cyc != 2) begin errors++; $display("[TB] FAIL single_latency_event: got %0d expected 2", cmd_rise_cyc - kd_rise_cyc); end
    end
    checks++; if (kd_rises != 1 || kd_falls != 1) begin errors++; $display("[TB] FAIL single_key_down_edges: got rises=%0d falls=%0d expected 1/1", kd_rises, kd_falls); end
    checks++; if (stab_err != 0) begin errors++; $display("[TB] FAIL single_hold_stable: got %0d violations expected 0", stab_err); end
    checks++; if (cif.in_cmd !== '0) begin errors++; $display("[TB] FAIL single_final_idle: got %0d expected 0", cif.in_cmd); end
  endtask

  task automatic test_bounce();
    int offset;
    clear_log();
    auto_ack  = 1'b1;
    ack_delay = 0;
    offset    = int'($urandom_range(0, SCAN_LEN - 1));
    repeat (offset) @(negedge clk);
    // Each level lasts exactly one scan, so no two consecutive scans agree.
    for (int i = 0; i < 8; i++) begin
      keys[0] = ~keys[0];
      repeat (SCAN_LEN) @(negedge clk);
    end
    keys[0] = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL bounce_no_cmd: got %0d commands expected 0", obs_q.size()); end
    checks++; if (kd_rises != 0) begin errors++; $display("[TB] FAIL bounce_key_down: got %0d rises expected 0", kd_rises); end
  endtask

  task automatic test_ghost();
    int ka, kb;
    auto_ack  = 1'b1;
    ack_delay = 0;
    for (int p = 0; p < 4; p++) begin
      if (p == 0) begin
        ka = 3;
        kb = 9;
      end else begin
        ka = int'($urandom_range(0, 19));
        do kb = int'($urandom_range(0, 19)); while (kb == ka);
      end
      clear_log();
      @(negedge clk);
      keys[ka] = 1'b1;
      keys[kb] = 1'b1;
      repeat (200) @(negedge clk);
      keys = '0;
      repeat (100) @(negedge clk);
      checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL ghost_no_cmd keys %0d+%0d: got %0d commands expected 0", ka, kb, obs_q.size()); end
      checks++; if (kd_rises != 0) begin errors++; $display("[TB] FAIL ghost_key_down keys %0d+%0d: got %0d rises expected 0", ka, kb, kd_rises); end
    end
  endtask

  task automatic test_backpressure();
    logic [`IC_N-1:0] exp_seq[$];
    logic [`IC_N-1:0] model_q[$];
    logic presenting;
    logic exp_over;
    do_reset();
    clear_log();
    presenting = 1'b0;
    exp_over   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      keys[k] = 1'b1;
      repeat (80) @(negedge clk);
      keys[k] = 1'b0;
      repeat (80) @(negedge clk);
      if (!presenting) begin
        presenting = 1'b1;
        exp_seq.push_back(exp_code(k));
      end else if (model_q.size() < FIFO_DEPTH) begin
        model_q.push_back(exp_code(k));
        exp_seq.push_back(exp_code(k));
      end else begin
        exp_over = 1'b1;
      end
    end
    checks++; if (cif.in_cmd !== exp_seq[0]) begin errors++; $display("[TB] FAIL bp_held_cmd: got %0d expected %0d", cif.in_cmd, exp_seq[0]); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("[TB] FAIL bp_single_presented: got %0d expected 1", obs_q.size()); end
    checks++; if (overflow !== exp_over) begin errors++; $display("[TB] FAIL bp_overflow_set: got %b expected %b", overflow, exp_over); end
    ack_delay = int'($urandom_range(0, 3));
    auto_ack  = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (obs_q.size() != exp_seq.size()) begin errors++; $display("[TB] FAIL bp_drain_count: got %0d expected %0d", obs_q.size(), exp_seq.size()); end
    for (int i = 0; i < exp_seq.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_seq[i]) begin errors++; $display("[TB] FAIL bp_drain_order[%0d]: got %0d expected %0d", i, obs_q[i], exp_seq[i]); end
    end
    checks++; if (stab_err != 0) begin errors++; $display("[TB] FAIL bp_handshake: got %0d violations expected 0", stab_err); end
    checks++; if (overflow !== exp_over) begin errors++; $display("[TB] FAIL bp_overflow_sticky: got %b expected %b", overflow, exp_over); end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    clear_log();
    auto_ack = 1'b0;
    @(negedge clk);
    keys[7] = 1'b1;
    while (cif.in_cmd !== exp_code(7) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (cif.in_cmd !== exp_code(7)) begin errors++; $display("[TB] FAIL rm_cmd_presented: got %0d expected %0d", cif.in_cmd, exp_code(7)); end
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    keys = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cif.in_cmd !== '0) begin errors++; $display("[TB] FAIL rm_in_cmd: got %0d expected 0", cif.in_cmd); end
    checks++; if (row_n !== 4'b1110) begin errors++; $display("[TB] FAIL rm_row_n: got %b expected 1110", row_n); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rm_overflow: got %b expected 0", overflow); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("[TB] FAIL rm_key_down: got %b expected 0", key_down); end
    obs_q.delete();
    auto_ack = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL rm_no_stale: got %0d commands expected 0", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [`IC_N-1:0] exp_seq[$];
    int k;
    do_reset();
    clear_log();
    auto_ack = 1'b1;
    for (int n = 0; n < 12; n++) begin
      k         = int'($urandom_range(0, 19));
      ack_delay = int'($urandom_range(0, 5));
      keys[k]   = 1'b1;
      repeat ($urandom_range(70, 130)) @(negedge clk);
      keys[k] = 1'b0;
      repeat ($urandom_range(70, 130)) @(negedge clk);
      exp_seq.push_back(exp_code(k));
    end
    repeat (50) @(negedge clk);
    checks++; if (obs_q.size() != exp_seq.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_seq.size()); end
    for (int i = 0; i < exp_seq.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_seq[i]) begin errors++; $display("[TB] FAIL rand_cmd[%0d]: got %0d expected %0d", i, obs_q[i], exp_seq[i]); end
    end
    checks++; if (kd_rises != exp_seq.size()) begin errors++; $display("[TB] FAIL rand_key_down: got %0d rises expected %0d", kd_rises, exp_seq.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rand_overflow: got %b expected 0", overflow); end
    checks++; if (stab_err != 0) begin errors++; $display("[TB] FAIL rand_handshake: got %0d violations expected 0", stab_err); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
